// File: rtl/hit_fifo.sv
// Hit record FIFO between the sample-test stage (R18) and the z-buffer (R19).
// Optional statistics outputs are enabled with `define HIT_FIFO_STATS_EN.
module hit_fifo #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hit_valid_R18H,
  input  logic signed [SIGFIG-1:0] hit_R18S [AXIS],
  input  logic        [SIGFIG-1:0] color_R18U [COLORS],
  output logic                     stall_R18H,
  output logic                     hit_valid_R19H,
  output logic signed [SIGFIG-1:0] hit_R19S [AXIS],
  output logic        [SIGFIG-1:0] color_R19U [COLORS],
  input  logic                     ready_R19H,
  output logic [$clog2(DEPTH):0]   occupancy,
`ifdef HIT_FIFO_STATS_EN
  output logic [31:0]              hit_count,
  output logic [$clog2(DEPTH):0]   max_occupancy,
`endif
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  // RADIX only describes the fixed-point format; data passes through untouched.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("hit_fifo: DEPTH must be a power of two >= 2");
  end
  if (RADIX < 0 || RADIX > SIGFIG) begin : g_bad_radix
    $error("hit_fifo: RADIX must lie within 0..SIGFIG");
  end

  logic signed [SIGFIG-1:0] mem_hit   [DEPTH][AXIS];
  logic        [SIGFIG-1:0] mem_color [DEPTH][COLORS];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ, occ_next;
  logic          push, pop;

  // Handshake: a side transfers on a rising edge when its valid is 1 and it is
  // not stalled (input) / the consumer is ready (output). Stall comes from
  // registered occupancy only, so a same-cycle pop never frees a slot for a push.
  assign stall_R18H     = (occ == FULL);
  assign hit_valid_R19H = (occ != '0);
  assign occupancy      = occ;
  assign push           = hit_valid_R18H && !stall_R18H;
  assign pop            = hit_valid_R19H && ready_R19H;

  always_comb begin
    occ_next = occ;
    if (push && !pop)      occ_next = occ + 1'b1;
    else if (!push && pop) occ_next = occ - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ_next;
      if (hit_valid_R18H && stall_R18H) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int a = 0; a < AXIS; a++)   mem_hit[wr_ptr][a]   <= hit_R18S[a];
      for (int c = 0; c < COLORS; c++) mem_color[wr_ptr][c] <= color_R18U[c];
    end
  end

  always_comb begin
    for (int a = 0; a < AXIS; a++)   hit_R19S[a]   = mem_hit[rd_ptr][a];
    for (int c = 0; c < COLORS; c++) color_R19U[c] = mem_color[rd_ptr][c];
  end

`ifdef HIT_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count     <= '0;
      max_occupancy <= '0;
    end else begin
      if (push) hit_count <= hit_count + 32'd1;
      if (occ_next > max_occupancy) max_occupancy <= occ_next;
    end
  end
`endif

endmodule

// File: doc/hit_fifo.md
HIT_FIFO -- requirements
Module: hit_fifo

Interface
REQ-001 SHALL have parameter SIGFIG, default 24, bits per coordinate and per color channel.
REQ-002 SHALL have parameter RADIX, default 10, fraction bits; pass-through only, no arithmetic.
REQ-003 SHALL have parameter AXIS, default 3, coordinates per hit (x,y,z).
REQ-004 SHALL have parameter COLORS, default 3, color channels per hit.
REQ-005 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  reset; asynchronous assertion, active-low (0 = reset).
REQ-008 SHALL have port hit_valid_R18H  input  1  hit record from sample test is valid this cycle.
REQ-009 SHALL have port hit_R18S  input  signed [SIGFIG-1:0] x [AXIS]  hit position.
REQ-010 SHALL have port color_R18U  input  unsigned [SIGFIG-1:0] x [COLORS]  hit color.
REQ-011 SHALL have port stall_R18H  output  1  FIFO full; upstream holds its record.
REQ-012 SHALL have port hit_valid_R19H  output  1  head entry valid toward z-buffer.
REQ-013 SHALL have port hit_R19S  output  signed [SIGFIG-1:0] x [AXIS]  head position.
REQ-014 SHALL have port color_R19U  output  unsigned [SIGFIG-1:0] x [COLORS]  head color.
REQ-015 SHALL have port ready_R19H  input  1  z-buffer consumes head this cycle.
REQ-016 SHALL have port occupancy  output  $clog2(DEPTH)+1  current entry count.
REQ-017 SHALL have port overflow  output  1  sticky flag: a valid hit arrived while full.

Function
REQ-018 SHALL accept (push) a record on a rising edge when hit_valid_R18H=1 and stall_R18H=0.
REQ-019 SHALL drive stall_R18H = (occupancy == DEPTH), decoded from registered state only; no combinational path from ready_R19H.
REQ-020 SHALL pop the head on a rising edge when hit_valid_R19H=1 and ready_R19H=1.
REQ-021 SHALL drive hit_valid_R19H = (occupancy != 0), with hit_R19S and color_R19U showing the head entry.
REQ-022 SHALL leave hit_R19S and color_R19U don't-care while hit_valid_R19H=0.
REQ-023 SHALL provide no bypass: a record pushed into an empty FIFO appears on the outputs exactly 1 cycle after acceptance.
REQ-024 SHALL, on simultaneous push and pop, store the new entry, remove the head, and leave occupancy unchanged.
REQ-025 SHALL refuse a push while full even when a pop occurs in the same cycle; the pop still occurs.
REQ-026 SHALL set overflow when hit_valid_R18H=1 and stall_R18H=1; the record is not stored and overflow remains 1 until reset.
REQ-027 SHALL wrap read and write pointers modulo DEPTH.
REQ-028 SHALL preserve order: entries leave in acceptance order, bit-exact, with no sign or width change.
REQ-029 SHALL hold the head stable while hit_valid_R19H=1 and ready_R19H=0.

Reset
REQ-030 SHALL, while rst=0, immediately clear the pointers, occupancy and overflow, forcing hit_valid_R19H=0 and stall_R18H=0.
REQ-031 SHALL discard every entry when reset asserts mid-operation; storage array contents need no reset.
REQ-032 SHALL accept no push on the first rising edge at which rst=0 is sampled.

Configuration
REQ-033 SHALL, with HIT_FIFO_STATS_EN defined, add output hit_count (32 bits, counts accepted pushes, wraps 2^32-1 -> 0).
REQ-034 SHALL, with HIT_FIFO_STATS_EN defined, add output max_occupancy ($clog2(DEPTH)+1 bits, high-water mark of occupancy); both stats outputs reset to 0.
REQ-035 SHALL, without HIT_FIFO_STATS_EN, omit both stats ports and their logic; all other behaviour is identical.

Verification
REQ-036 SHALL cover single hit: push x=0x000400, y=0x000800, z=0x000001, color=0x3FF,0,0 with ready=1 -> valid_R19H=1 next cycle with identical data, popped, occupancy back to 0.
REQ-037 SHALL cover fill with ready=0 and 8 pushes (DEPTH=8) -> occupancy=8, stall=1; a 9th valid -> overflow=1, entry 9 absent from the drained order 1..8.
REQ-038 SHALL cover full with ready=1 and valid=1 -> pop occurs, push refused that cycle, occupancy=7, stall=0 next cycle.
REQ-039 SHALL cover continuous stream with occupancy=3: push and pop every cycle for 20 cycles -> occupancy stays 3, order preserved through pointer wrap.
REQ-040 SHALL cover reset mid-stream with occupancy=5: assert rst=0 between clock edges -> valid_R19H=0 and occupancy=0 immediately; after release the first push is output alone.
REQ-041 SHALL cover stats with HIT_FIFO_STATS_EN: 12 pushes, peak occupancy 6 -> hit_count=12, max_occupancy=6.
